// File: rtl/bram_bist_seq.sv
// rtl/bram_bist_seq.sv - single-port BRAM built-in self-test sequencer
//
// Writes an address-derived pattern over [addr_lo, addr_hi], reads the window
// back, compares every word and reports pass / error count / first bad address.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start                        one-cycle pulse, accepted in IDLE or DONE
//   addr_lo, addr_hi, seed       window bounds (inclusive) and pattern offset
//   bram_ren, bram_wen           BRAM read / write strobes (never both high)
//   bram_addr, bram_wdata        BRAM address and write data
//   bram_rdata                   BRAM read data, RD_LATENCY cycles after REN
//   busy, done, pass             status; pass is meaningful while done=1
//   err_cnt, first_err_addr      saturating mismatch count, first bad address
module bram_bist_seq #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 18,
    parameter int RD_LATENCY    = 1,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_WIDTH-1:0]    addr_lo,
    input  logic [ADDR_WIDTH-1:0]    addr_hi,
    input  logic [ADDR_WIDTH-1:0]    seed,
    output logic                     bram_ren,
    output logic                     bram_wen,
    output logic [ADDR_WIDTH-1:0]    bram_addr,
    output logic [DATA_WIDTH-1:0]    bram_wdata,
    input  logic [DATA_WIDTH-1:0]    bram_rdata,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt,
    output logic [ADDR_WIDTH-1:0]    first_err_addr
);

    localparam int PW = (DATA_WIDTH > ADDR_WIDTH + 20) ? DATA_WIDTH : ADDR_WIDTH + 20;
    localparam logic [2:0] DRAIN_LAST = 3'(RD_LATENCY);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   lo_q, hi_q, seed_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [2:0]              drain_q, drain_d;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   wr_pat;

    // Per-read tracking: valid, expected word and address travel with the read.
    logic                    pv_q    [RD_LATENCY];
    logic [DATA_WIDTH-1:0]   pexp_q  [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]   paddr_q [RD_LATENCY];

    // Returned data is registered before the compare to keep the BRAM output
    // path short; the extra drain cycle below covers this stage.
    logic                    cmp_v_q;
    logic [DATA_WIDTH-1:0]   cmp_exp_q, cmp_rdata_q;
    logic [ADDR_WIDTH-1:0]   cmp_addr_q;
    logic                    mismatch;
    logic [ERR_CNT_WIDTH-1:0] err_q;
    logic [ADDR_WIDTH-1:0]   first_q;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [ADDR_WIDTH-1:0] s);
        logic [ADDR_WIDTH-1:0] sum;
        sum = a + s;
        return DATA_WIDTH'(PW'(sum) | (PW'(sum) << 20) | PW'(20'h55000));
    endfunction

    assign wr_pat = pattern(addr_q, seed_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        drain_d = drain_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    addr_d  = addr_lo;
                    state_d = (addr_lo > addr_hi) ? S_DONE : S_WRITE;
                end
            end
            S_WRITE: begin
                // Compare the unincremented address so a window ending at the
                // top of the address space never needs the wrapped value.
                if (addr_q == hi_q) begin
                    state_d = S_READ;
                    addr_d  = lo_q;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_READ: begin
                if (addr_q == hi_q) begin
                    state_d = S_DRAIN;
                    drain_d = 3'd0;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // RD_LATENCY cycles for the last word plus one for the compare stage.
                if (drain_q == DRAIN_LAST) state_d = S_DONE;
                else                       drain_d = drain_q + 3'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            seed_q  <= '0;
            wdata_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
            if (accept) begin
                lo_q   <= addr_lo;
                hi_q   <= addr_hi;
                seed_q <= seed;
            end
            if (bram_wen) wdata_q <= wr_pat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                pv_q[i]    <= 1'b0;
                pexp_q[i]  <= '0;
                paddr_q[i] <= '0;
            end
            cmp_v_q     <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_rdata_q <= '0;
            cmp_addr_q  <= '0;
        end else begin
            pv_q[0]    <= bram_ren;
            pexp_q[0]  <= wr_pat;
            paddr_q[0] <= addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv_q[i]    <= pv_q[i-1];
                pexp_q[i]  <= pexp_q[i-1];
                paddr_q[i] <= paddr_q[i-1];
            end
            cmp_v_q     <= pv_q[RD_LATENCY-1];
            cmp_exp_q   <= pexp_q[RD_LATENCY-1];
            cmp_addr_q  <= paddr_q[RD_LATENCY-1];
            cmp_rdata_q <= bram_rdata;
        end
    end

    // Case inequality so an undriven (X) read counts as a failure in simulation.
    assign mismatch = cmp_v_q && (cmp_rdata_q !== cmp_exp_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q   <= '0;
            first_q <= '0;
        end else if (accept) begin
            err_q   <= '0;
            first_q <= '0;
        end else if (mismatch) begin
            if (err_q != '1) err_q <= err_q + ERR_CNT_WIDTH'(1);
            if (err_q == '0) first_q <= cmp_addr_q;
        end
    end

    assign bram_wen       = (state_q == S_WRITE);
    assign bram_ren       = (state_q == S_READ);
    assign bram_addr      = addr_q;
    assign bram_wdata     = bram_wen ? wr_pat : wdata_q;
    assign busy           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_q == '0);
    assign err_cnt        = err_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_bram_bist_seq.sv
// tb/tb_bram_bist_seq.sv - self-checking bench for bram_bist_seq
module tb_bram_bist_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: 10/18, latency 1
    logic a_start = 0; logic [9:0] a_lo = 0, a_hi = 0, a_seed = 0;
    logic a_ren, a_wen, a_busy, a_done, a_pass;
    logic [9:0] a_addr, a_first; logic [17:0] a_wdata, a_rdata; logic [15:0] a_err;
    // Instance B: 11/9, latency 1
    logic b_start = 0; logic [10:0] b_lo = 0, b_hi = 0, b_seed = 0;
    logic b_ren, b_wen, b_busy, b_done, b_pass;
    logic [10:0] b_addr, b_first; logic [8:0] b_wdata, b_rdata; logic [15:0] b_err;
    // Instance C: 10/18, latency 2
    logic c_start = 0; logic [9:0] c_lo = 0, c_hi = 0, c_seed = 0;
    logic c_ren, c_wen, c_busy, c_done, c_pass;
    logic [9:0] c_addr, c_first; logic [17:0] c_wdata, c_rdata; logic [15:0] c_err;

    bram_bist_seq #(.ADDR_WIDTH(10), .DATA_WIDTH(18), .RD_LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .addr_lo(a_lo), .addr_hi(a_hi), .seed(a_seed),
        .bram_ren(a_ren), .bram_wen(a_wen), .bram_addr(a_addr), .bram_wdata(a_wdata),
        .bram_rdata(a_rdata), .busy(a_busy), .done(a_done), .pass(a_pass),
        .err_cnt(a_err), .first_err_addr(a_first));
    bram_bist_seq #(.ADDR_WIDTH(11), .DATA_WIDTH(9), .RD_LATENCY(1)) u_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .addr_lo(b_lo), .addr_hi(b_hi), .seed(b_seed),
        .bram_ren(b_ren), .bram_wen(b_wen), .bram_addr(b_addr), .bram_wdata(b_wdata),
        .bram_rdata(b_rdata), .busy(b_busy), .done(b_done), .pass(b_pass),
        .err_cnt(b_err), .first_err_addr(b_first));
    bram_bist_seq #(.ADDR_WIDTH(10), .DATA_WIDTH(18), .RD_LATENCY(2)) u_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .addr_lo(c_lo), .addr_hi(c_hi), .seed(c_seed),
        .bram_ren(c_ren), .bram_wen(c_wen), .bram_addr(c_addr), .bram_wdata(c_wdata),
        .bram_rdata(c_rdata), .busy(c_busy), .done(c_done), .pass(c_pass),
        .err_cnt(c_err), .first_err_addr(c_first));

    // Behavioural BRAMs; inj[] flips bit 0 of data read from marked addresses.
    bit inj [2048];
    logic [17:0] mem_a [1024];
    logic [8:0]  mem_b [2048];
    logic [17:0] mem_c [1024];
    logic [17:0] c_rd1;

    always @(posedge clk) begin
        if (a_wen) mem_a[a_addr] <= a_wdata;
        a_rdata <= mem_a[a_addr] ^ ((a_ren && inj[a_addr]) ? 18'd1 : 18'd0);
        if (b_wen) mem_b[b_addr] <= b_wdata;
        b_rdata <= mem_b[b_addr] ^ ((b_ren && inj[b_addr]) ? 9'd1 : 9'd0);
        if (c_wen) mem_c[c_addr] <= c_wdata;
        c_rd1   <= mem_c[c_addr] ^ ((c_ren && inj[c_addr]) ? 18'd1 : 18'd0);
        c_rdata <= c_rd1;
    end

    // View of whichever instance is under test.
    int cur_sel = 0;
    logic m_ren, m_wen, m_busy, m_done, m_pass;
    logic [10:0] m_addr, m_first; logic [17:0] m_wdata; logic [15:0] m_err;
    always_comb begin
        m_ren = 0; m_wen = 0; m_busy = 0; m_done = 0; m_pass = 0;
        m_addr = '0; m_first = '0; m_wdata = '0; m_err = '0;
        case (cur_sel)
            0: begin
                m_ren = a_ren; m_wen = a_wen; m_busy = a_busy; m_done = a_done; m_pass = a_pass;
                m_addr = {1'b0, a_addr}; m_first = {1'b0, a_first}; m_wdata = a_wdata; m_err = a_err;
            end
            1: begin
                m_ren = b_ren; m_wen = b_wen; m_busy = b_busy; m_done = b_done; m_pass = b_pass;
                m_addr = b_addr; m_first = b_first; m_wdata = {9'b0, b_wdata}; m_err = b_err;
            end
            default: begin
                m_ren = c_ren; m_wen = c_wen; m_busy = c_busy; m_done = c_done; m_pass = c_pass;
                m_addr = {1'b0, c_addr}; m_first = {1'b0, c_first}; m_wdata = c_wdata; m_err = c_err;
            end
        endcase
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference pattern straight from the definition.
    function automatic logic [17:0] pat(input int a, input int sd, input int aw, input int dw);
        longint s, p;
        s = longint'((a + sd) % (1 << aw));
        p = s | (s << 20) | 64'h55000;
        return 18'(p & ((64'd1 << dw) - 1));
    endfunction

    // Strobe monitor
    bit mon_on = 0;
    int mon_lo, mon_seed, mon_aw, mon_dw;
    int wr_cnt, rd_cnt, both_cnt, seq_bad, dat_bad;
    logic [17:0] written [2048];

    always @(negedge clk) begin
        if (mon_on) begin
            if (m_wen) begin
                if (m_addr !== 11'(mon_lo + wr_cnt)) seq_bad++;
                if (m_wdata !== pat(int'(m_addr), mon_seed, mon_aw, mon_dw)) dat_bad++;
                written[m_addr] = m_wdata;
                wr_cnt++;
            end
            if (m_ren) begin
                if (m_addr !== 11'(mon_lo + rd_cnt)) seq_bad++;
                rd_cnt++;
            end
            if (m_wen && m_ren) both_cnt++;
        end
    end

    task automatic set_start(input int sel, input bit v, input int lo, input int hi, input int sd);
        case (sel)
            0:       begin a_start = v; a_lo = lo[9:0];  a_hi = hi[9:0];  a_seed = sd[9:0];  end
            1:       begin b_start = v; b_lo = lo[10:0]; b_hi = hi[10:0]; b_seed = sd[10:0]; end
            default: begin c_start = v; c_lo = lo[9:0];  c_hi = hi[9:0];  c_seed = sd[9:0];  end
        endcase
    endtask

    task automatic clear_inj();
        for (int i = 0; i < 2048; i++) inj[i] = 0;
    endtask

    task automatic run_test(input string tag, input int sel, input int lo, input int hi,
                            input int sd, input bit restart);
        int lat, n, exp_err, exp_first, exp_cyc, cyc, busy_drop;
        lat = (sel == 2) ? 2 : 1;
        n = (lo > hi) ? 0 : hi - lo + 1;
        exp_err = 0; exp_first = 0;
        for (int a = lo; a <= hi; a++)
            if (inj[a]) begin
                if (exp_err == 0) exp_first = a;
                exp_err++;
            end
        exp_cyc = (n == 0) ? 0 : 2 * n + lat + 1;
        cur_sel = sel;
        mon_lo = lo; mon_seed = sd;
        mon_aw = (sel == 1) ? 11 : 10; mon_dw = (sel == 1) ? 9 : 18;
        wr_cnt = 0; rd_cnt = 0; both_cnt = 0; seq_bad = 0; dat_bad = 0;
        @(negedge clk);
        set_start(sel, 1, lo, hi, sd);
        mon_on = 1;
        @(posedge clk); #1;
        set_start(sel, 0, lo, hi, sd);
        cyc = 0; busy_drop = 0;
        while (!m_done && cyc < exp_cyc + 20) begin
            if (!m_busy) busy_drop++;
            if (restart && cyc == 3) set_start(sel, 1, lo + 1, hi, sd + 1);
            @(posedge clk); #1;
            cyc++;
            if (restart) set_start(sel, 0, lo, hi, sd);
        end
        @(negedge clk);
        mon_on = 0;
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_done"}, m_done, 1);
        check({tag, "_busy_end"}, m_busy, 0);
        check({tag, "_busy_gap"}, busy_drop, 0);
        check({tag, "_pass"}, m_pass, (exp_err == 0));
        check({tag, "_err_cnt"}, m_err, exp_err);
        check({tag, "_first_err"}, m_first, exp_first);
        check({tag, "_writes"}, wr_cnt, n);
        check({tag, "_reads"}, rd_cnt, n);
        check({tag, "_overlap"}, both_cnt, 0);
        check({tag, "_addr_seq"}, seq_bad, 0);
        check({tag, "_wdata"}, dat_bad, 0);
    endtask

    initial begin
        int lo, hi, sd, sel, k;
        clear_inj();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_a", {a_ren, a_wen, a_addr, a_wdata, a_busy, a_done, a_pass, a_err, a_first}, 0);
        check("reset_outs_c", {c_ren, c_wen, c_addr, c_wdata, c_busy, c_done, c_pass, c_err, c_first}, 0);
        @(negedge clk);
        rst_n = 1;

        run_test("full512", 0, 0, 511, 0, 0);
        check("word5", written[5], 18'h15005);

        inj[100] = 1; inj[300] = 1;
        run_test("inj2", 0, 0, 511, 0, 0);
        check("inj2_first_100", m_first, 100);
        clear_inj();

        run_test("b_top", 1, 1024, 2047, 3, 0);
        check("b_word1024", written[1024], 18'h003);

        run_test("empty", 0, 20, 10, 0, 0);

        // Reset in the middle of READ
        cur_sel = 0;
        @(negedge clk);
        set_start(0, 1, 0, 63, 7);
        @(posedge clk); #1;
        set_start(0, 0, 0, 63, 7);
        repeat (70) @(posedge clk);
        #3;
        check("mid_read_ren", a_ren, 1);
        rst_n = 0;
        #1;
        check("async_rst_outs", {a_ren, a_wen, a_addr, a_wdata, a_busy, a_done, a_pass, a_err, a_first}, 0);
        repeat (2) @(negedge clk);
        check("rst_held_outs", {a_ren, a_wen, a_busy, a_done}, 0);
        rst_n = 1;
        run_test("post_rst", 0, 0, 15, 9, 0);

        run_test("lat2_restart", 2, 0, 63, 5, 1);

        for (int i = 0; i < 6; i++) begin
            sel = (i % 2 == 0) ? 0 : 2;
            lo = $urandom_range(0, 980);
            hi = lo + $urandom_range(0, 40);
            if (i == 3) begin lo = 1000; hi = 1023; end
            if (i == 4) begin k = lo; lo = hi + 1; hi = k; end
            sd = $urandom_range(0, 1023);
            clear_inj();
            if (lo <= hi) begin
                k = $urandom_range(0, 3);
                for (int j = 0; j < k; j++) inj[$urandom_range(lo, hi)] = 1;
            end
            run_test($sformatf("rnd%0d", i), sel, lo, hi, sd, 0);
        end
        clear_inj();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
